// File: rtl/ac_div_pkg.sv
// Shared types and constants for the sequential 16/8 approximate divider.
package ac_div_pkg;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned QUOT_W     = 16;

  // Quotient reported for a zero divisor.
  localparam logic [QUOT_W-1:0] DIV0_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/ac_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module ac_div_step
  import ac_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   pr_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   pr_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W:0] pr_shift;
  logic [DIVISOR_W:0] divisor_ext;

  // pr_i < divisor on entry, so the 9-bit shifted value cannot overflow the compare.
  always_comb begin
    pr_shift    = {pr_i[DIVISOR_W-1:0], bit_i};
    divisor_ext = {1'b0, divisor_i};
    if (pr_shift >= divisor_ext) begin
      pr_o    = pr_shift - divisor_ext;
      q_bit_o = 1'b1;
    end else begin
      pr_o    = pr_shift;
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/ac_seq_div16.sv
// Sequential radix-2 restoring divider, 16-bit dividend / 8-bit divisor, with optional
// truncation of the low APPROX_BITS quotient iterations (those bits read as zero).
module ac_seq_div16
  import ac_div_pkg::*;
#(
  parameter int unsigned APPROX_BITS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned N_ITER  = DIVIDEND_W - APPROX_BITS;
  localparam logic [3:0]  CntInit = 4'(N_ITER - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [DIVISOR_W:0]     pr_q, pr_d;
  logic [DIVIDEND_W-1:0]  dsr_q, dsr_d;
  logic [DIVISOR_W-1:0]   divisor_q, divisor_d;
  logic [QUOT_W-1:0]      qacc_q, qacc_d;
  logic [QUOT_W-1:0]      quot_q, quot_d;
  logic [DIVISOR_W-1:0]   rem_q, rem_d;
  logic                   dbz_q, dbz_d;
  logic                   ov_q, ov_d;

  logic [DIVISOR_W:0]     pr_step;
  logic                   q_bit;
  logic [QUOT_W-1:0]      qacc_next;

  ac_div_step u_step (
    .pr_i      (pr_q),
    .bit_i     (dsr_q[DIVIDEND_W-1]),
    .divisor_i (divisor_q),
    .pr_o      (pr_step),
    .q_bit_o   (q_bit)
  );

  assign qacc_next   = {qacc_q[QUOT_W-2:0], q_bit};
  assign in_ready    = (state_q == StIdle);
  assign out_valid   = ov_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

  // Next-state and datapath control; registers hold unless a state acts on them.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pr_d      = pr_q;
    dsr_d     = dsr_q;
    divisor_d = divisor_q;
    qacc_d    = qacc_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    ov_d      = ov_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          divisor_d = divisor;
          if (divisor == '0) begin
            state_d = StDone;
            quot_d  = DIV0_QUOT;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            ov_d    = 1'b1;
          end else begin
            state_d = StCalc;
            pr_d    = '0;
            dsr_d   = dividend;
            cnt_d   = CntInit;
            qacc_d  = '0;
          end
        end
      end
      StCalc: begin
        pr_d   = pr_step;
        dsr_d  = {dsr_q[DIVIDEND_W-2:0], 1'b0};
        qacc_d = qacc_next;
        if (cnt_q == '0) begin
          state_d = StDone;
          // Skipped iterations land as zero LSBs.
          quot_d  = qacc_next << APPROX_BITS;
          rem_d   = pr_step[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
          ov_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          ov_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pr_q      <= '0;
      dsr_q     <= '0;
      divisor_q <= '0;
      qacc_q    <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pr_q      <= pr_d;
      dsr_q     <= dsr_d;
      divisor_q <= divisor_d;
      qacc_q    <= qacc_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
      ov_q      <= ov_d;
    end
  end

endmodule
